// File: rtl/ou_pkg.sv
// ou_pkg: shared state, glyph codes and helpers for the output-unit display sequencer
package ou_pkg;
  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;
  typedef enum logic [2:0] {G_DIGIT, G_BLANK, G_MINUS, G_E, G_R} glyph_t;
  localparam int NUM_POS = 6;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_R = 7'h2F;
  function automatic logic [3:0] add3(input logic [3:0] d);
    return d >= 4'd5 ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: maps a BCD digit or a special glyph to active-low {g,f,e,d,c,b,a}
module seg7_decode
  import ou_pkg::*;
(
  input  logic [3:0] digit,
  input  glyph_t     sel,
  output logic [6:0] seg
);
  logic [6:0] dseg;
  // digit table, then glyph override
  always_comb begin
    case (digit)
      4'd0: dseg = SEG_0;
      4'd1: dseg = SEG_1;
      4'd2: dseg = SEG_2;
      4'd3: dseg = SEG_3;
      4'd4: dseg = SEG_4;
      4'd5: dseg = SEG_5;
      4'd6: dseg = SEG_6;
      4'd7: dseg = SEG_7;
      4'd8: dseg = SEG_8;
      4'd9: dseg = SEG_9;
      default: dseg = SEG_BLANK;
    endcase
    seg = sel == G_DIGIT ? dseg : sel == G_MINUS ? SEG_MINUS : sel == G_E ? SEG_E :
          sel == G_R ? SEG_R : SEG_BLANK;
  end
endmodule

// File: rtl/bcd_display_sequencer.sv
// bcd_display_sequencer: double-dabble BCD conversion with a double-buffered 6-digit scan; option LEADING_ZERO_BLANK_EN
module bcd_display_sequencer
  import ou_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        result_valid,
  input  logic [15:0] result,
  input  logic        result_neg,
  input  logic        result_err,
  output logic        ready,
  output logic        busy,
  output logic [5:0]  an,
  output logic [6:0]  seg
);
  localparam int CW = $clog2(SCAN_DIV);
  state_t state, state_n;
  logic [15:0] bin;
  logic [19:0] bcd, adj, bcd_step, buf_bcd, buf_bcd_n;
  logic [3:0] cnt, nib;
  logic neg_q, err_q, buf_neg, buf_err, buf_vld, buf_neg_n, buf_err_n, buf_vld_n;
  logic [CW-1:0] scnt;
  logic [2:0] idx, idx_n;
  logic take, done, tick, lz;
  glyph_t sel;
  logic [6:0] seg_n;
  assign take = result_valid && ready;
  assign done = state == CONV && cnt == 4'd15;
  assign tick = scnt == CW'(SCAN_DIV - 1);
  assign idx_n = tick ? (idx == 3'(NUM_POS - 1) ? 3'd0 : idx + 3'd1) : idx;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: capture starts a conversion, the 16th step ends it
  always_comb state_n = take ? CONV : done ? SHOW : state;
  // handshake outputs
  always_comb begin
    ready = state != CONV;
    busy = state == CONV;
  end
  // one double-dabble step: add 3 to large nibbles, then shift the combined register
  always_comb begin
    adj = '0;
    for (int i = 0; i < 5; i++) adj[4*i +: 4] = add3(bcd[4*i +: 4]);
    bcd_step = {adj[18:0], bin[15]};
  end
  // conversion datapath: load on capture, shift while converting
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      err_q <= 1'b0;
    end else if (take) begin
      bin <= result;
      bcd <= '0;
      cnt <= '0;
      neg_q <= result_neg;
      err_q <= result_err;
    end else if (state == CONV) begin
      bin <= {bin[14:0], 1'b0};
      bcd <= bcd_step;
      cnt <= cnt + 4'd1;
    end
  // display buffer only changes when a conversion completes, so the old value stays up during CONV
  always_comb begin
    buf_bcd_n = done ? bcd_step : buf_bcd;
    buf_neg_n = done ? neg_q : buf_neg;
    buf_err_n = done ? err_q : buf_err;
    buf_vld_n = done | buf_vld;
  end
  // display buffer register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      buf_bcd <= '0;
      buf_neg <= 1'b0;
      buf_err <= 1'b0;
      buf_vld <= 1'b0;
    end else begin
      buf_bcd <= buf_bcd_n;
      buf_neg <= buf_neg_n;
      buf_err <= buf_err_n;
      buf_vld <= buf_vld_n;
    end
`ifdef LEADING_ZERO_BLANK_EN
  assign lz = idx_n != 3'd0 && (buf_bcd_n >> {idx_n, 2'b00}) == 20'd0;
`else
  assign lz = 1'b0;
`endif
  // glyph selection for the position about to be driven, from the buffer as it will be
  always_comb begin
    nib = 4'(buf_bcd_n >> {idx_n, 2'b00});
    sel = !buf_vld_n ? G_BLANK :
          idx_n == 3'(NUM_POS - 1) ? (buf_neg_n && !buf_err_n ? G_MINUS : G_BLANK) :
          buf_err_n ? (idx_n == 3'd2 ? G_E : idx_n < 3'd2 ? G_R : G_BLANK) :
          lz ? G_BLANK : G_DIGIT;
  end
  seg7_decode u_dec (.digit(nib), .sel(sel), .seg(seg_n));
  // scan counter, index and registered an/seg so both change on the same edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scnt <= '0;
      idx <= '0;
      an <= 6'h3F;
      seg <= SEG_BLANK;
    end else begin
      scnt <= tick ? '0 : scnt + CW'(1);
      idx <= idx_n;
      an <= ~(6'd1 << idx_n);
      seg <= seg_n;
    end
endmodule
